// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with registered one-hot grant
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   en           arbiter enable; low releases any grant
//   req[7:0]     level request per client
//   grant[7:0]   registered one-hot grant, zero when no owner
//   grant_idx    binary index of owner; holds last owner while grant_valid=0
//   grant_valid  high when grant is non-zero
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Adds a hold counter that forces a hand-off after MAX_HOLD cycles of
//   ownership when another client is waiting. MAX_HOLD is ignored otherwise.

module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] last;

    // Candidate mask: while granted, the owner is excluded so the search
    // finds the next waiting client. In IDLE, the previous owner is still
    // eligible but comes last in the scan order.
    logic [7:0] cand;
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] probe;

    always_comb begin
        cand = req;
        if (state == GRANT) begin
            cand = req & ~(8'b1 << last);
        end
        win_found = 1'b0;
        win_idx   = last;
        probe     = last;
        for (int k = 1; k <= 8; k++) begin
            probe = last + 3'(k);
            if (!win_found && cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    logic timeout;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;

    // In GRANT, win_found already means some other client is waiting.
    assign timeout = (hold_cnt == HOLD_LAST) && win_found;
`else
    logic unused_cfg;
    assign unused_cfg = ^8'(MAX_HOLD);
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 3'd7;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state       <= GRANT;
                        grant       <= 8'b1 << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        last        <= win_idx;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt    <= 8'd0;
`endif
                    end else begin
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end else if (req[last] && !timeout) begin
`ifdef ARB_TIMEOUT_EN
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end else if (win_found) begin
                        // Release or timeout: hand off on this edge, no dead cycle.
                        grant       <= 8'b1 << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        last        <= win_idx;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt    <= 8'd0;
`endif
                    end else begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 8'h00;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8

module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;

    int checks;
    int errors;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;
        step();
        checks++;
        if (grant !== 8'h00) begin
            errors++;
            $display("FAIL reset_grant: got %h want %h", grant, 8'h00);
        end
        checks++;
        if (grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d want %0d", grant_idx, 0);
        end
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want %b", grant_valid, 1'b0);
        end
        rst_n = 1'b1;
        req   = 8'h00;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h01;
        step();
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got %h/%0d/%b want 01/0/1", grant, grant_idx, grant_valid);
        end
        req = 8'h00;
        step();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL single_release: got %h/%0d/%b want 00/0/0", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_idx;
        logic [7:0] exp_grant;
        do_reset();
        req = 8'hFF;
        step();
        exp_idx   = 3'd0;
        exp_grant = 8'h01;
        checks++;
        if (grant !== exp_grant || grant_idx !== exp_idx) begin
            errors++;
            $display("FAIL rot_first: got %h/%0d want %h/%0d", grant, grant_idx, exp_grant, exp_idx);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (grant !== exp_grant || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot_hold%0d: got %h want %h", k, grant, exp_grant);
            end
            req = 8'hFF & ~exp_grant;
            step();
            exp_idx   = exp_idx + 3'd1;
            exp_grant = {exp_grant[6:0], exp_grant[7]};
            checks++;
            if (grant !== exp_grant || grant_idx !== exp_idx || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot_handoff%0d: got %h/%0d/%b want %h/%0d/1",
                         k, grant, grant_idx, grant_valid, exp_grant, exp_idx);
            end
            req = 8'hFF;
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req = 8'h20;
        step();
        checks++;
        if (grant !== 8'h20 || grant_idx !== 3'd5) begin
            errors++;
            $display("FAIL wrap_owner5: got %h/%0d want 20/5", grant, grant_idx);
        end
        req = 8'b0000_1001;
        step();
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL wrap_to0: got %h/%0d want 01/0", grant, grant_idx);
        end
        req = 8'b0000_1000;
        step();
        checks++;
        if (grant !== 8'h08 || grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL skip_to3: got %h/%0d want 08/3", grant, grant_idx);
        end
        req = 8'h00;
        step();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL wrap_idle: got %h/%0d/%b want 00/3/0", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_enable();
        do_reset();
        req = 8'h04;
        step();
        checks++;
        if (grant !== 8'h04 || grant_idx !== 3'd2) begin
            errors++;
            $display("FAIL en_owner2: got %h/%0d want 04/2", grant, grant_idx);
        end
        en = 1'b0;
        step();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd2) begin
            errors++;
            $display("FAIL en_drop: got %h/%0d/%b want 00/2/0", grant, grant_idx, grant_valid);
        end
        step();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_stay_off: got %h/%b want 00/0", grant, grant_valid);
        end
        en  = 1'b1;
        req = 8'h0C;
        step();
        checks++;
        if (grant !== 8'h08 || grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL en_resume: got %h/%0d want 08/3", grant, grant_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h10;
        step();
        checks++;
        if (grant !== 8'h10 || grant_idx !== 3'd4) begin
            errors++;
            $display("FAIL mid_owner4: got %h/%0d want 10/4", grant, grant_idx);
        end
        rst_n = 1'b0;
        req   = 8'hFF;
        step();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h/%0d/%b want 00/0/0", grant, grant_idx, grant_valid);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_client0: got %h/%0d/%b want 01/0/1", grant, grant_idx, grant_valid);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_glitch();
        do_reset();
        req = 8'h01;
        step();
        req = 8'h05;
        step();
        checks++;
        if (grant !== 8'h01) begin
            errors++;
            $display("FAIL glitch_hold: got %h want 01", grant);
        end
        req = 8'h01;
        step();
        req = 8'h00;
        step();
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_ignored: got %h/%b want 00/0", grant, grant_valid);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req = 8'h03;
        step();
        checks++;
        if (grant !== 8'h01) begin
            errors++;
            $display("FAIL hold_start: got %h want 01", grant);
        end
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            step();
            checks++;
            if (grant !== 8'h01) begin
                errors++;
                $display("FAIL tmo_c0_%0d: got %h want 01", c, grant);
            end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (grant !== 8'h02) begin
                errors++;
                $display("FAIL tmo_c1_%0d: got %h want 02", c, grant);
            end
        end
        step();
        checks++;
        if (grant !== 8'h01) begin
            errors++;
            $display("FAIL tmo_back0: got %h want 01", grant);
        end
`else
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (grant !== 8'h01) begin
                errors++;
                $display("FAIL hold_forever%0d: got %h want 01", c, grant);
            end
        end
`endif
        req = 8'h01;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (grant !== 8'h01 || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_alone%0d: got %h want 01", c, grant);
            end
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        req    = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_wrap_skip();
        test_enable();
        test_reset_mid();
        test_glitch();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
